// File: rtl/mux_arbitrado_pkg.sv
// rtl/mux_arbitrado_pkg.sv - shared constants and round-robin search helper for mux_arbitrado
package mux_arbitrado_pkg;

  localparam logic MODO_FIXO  = 1'b0;
  localparam logic MODO_RR    = 1'b1;
  localparam int   CONTADOR_W = 16;

  // Widest request vector the search helper accepts; callers zero-extend into it
  localparam int RR_MAX_CANAIS = 64;
  localparam int RR_IDX_W      = $clog2(RR_MAX_CANAIS);

  // Index of the first set request at or after ponteiro, wrapping at num_canais.
  // Returns -1 when no request is set. Scanning from the far end downwards lets the
  // closest hit overwrite the others, so the result is the first one in search order.
  function automatic int rr_busca(input logic [RR_MAX_CANAIS-1:0] pedidos,
                                  input int                       ponteiro,
                                  input int                       num_canais);
    int idx;
    int achado;
    achado = -1;
    for (int k = RR_MAX_CANAIS - 1; k >= 0; k--) begin
      if (k < num_canais) begin
        idx = ponteiro + k;
        if (idx >= num_canais) begin
          idx = idx - num_canais;
        end
        if (pedidos[idx[RR_IDX_W-1:0]]) begin
          achado = idx;
        end
      end
    end
    return achado;
  endfunction

endpackage

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - combinational round-robin arbiter; pointer register lives in the parent
module arbitro_rr
  import mux_arbitrado_pkg::*;
#(
  parameter int  NUM_CANAIS = 4,
  localparam int SEL_W      = $clog2(NUM_CANAIS)
) (
  input  logic [NUM_CANAIS-1:0] pedidos_i,
  input  logic [SEL_W-1:0]      ponteiro_i,
  input  logic                  habilita_i,
  output logic [NUM_CANAIS-1:0] concessao_o,
  output logic [SEL_W-1:0]      indice_o,
  output logic                  encontrado_o
);

  logic [RR_MAX_CANAIS-1:0] pedidos_ext;
  int                       busca;

  // Search for the first requester starting at the pointer
  always_comb begin
    pedidos_ext                 = '0;
    pedidos_ext[NUM_CANAIS-1:0] = pedidos_i;
    busca                       = rr_busca(pedidos_ext, int'(ponteiro_i), NUM_CANAIS);
  end

  assign encontrado_o = (busca >= 0);
  assign indice_o     = busca[SEL_W-1:0];

  // Candidate exists regardless of enable; the one-hot grant only when enabled
  always_comb begin
    concessao_o = '0;
    if (habilita_i && encontrado_o) begin
      concessao_o[indice_o] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_arbitrado.sv
// rtl/mux_arbitrado.sv - N-channel registered mux with valid/ready handshakes; optional MUX_ARBITRADO_CONTADOR_EN transfer counter
module mux_arbitrado
  import mux_arbitrado_pkg::*;
#(
  parameter int  LARGURA    = 8,
  parameter int  NUM_CANAIS = 4,
  localparam int SEL_W      = $clog2(NUM_CANAIS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CANAIS*LARGURA-1:0] entradas,
  input  logic [NUM_CANAIS-1:0]         validos,
  output logic [NUM_CANAIS-1:0]         prontos,
  input  logic                          modo,
  input  logic [SEL_W-1:0]              controle,
  output logic [LARGURA-1:0]            resultado,
  output logic                          resultado_valido,
  input  logic                          resultado_pronto,
  output logic [SEL_W-1:0]              canal_atual
`ifdef MUX_ARBITRADO_CONTADOR_EN
  ,
  output logic [CONTADOR_W-1:0]         transferencias
`endif
);

  logic [LARGURA-1:0]    resultado_q, resultado_d;
  logic                  valido_q, valido_d;
  logic [SEL_W-1:0]      canal_q, canal_d;
  logic [SEL_W-1:0]      ponteiro_q, ponteiro_d;

  logic                  carregar;
  logic                  transferir;
  logic                  controle_ok;
  logic                  fixo_concede;
  logic [NUM_CANAIS-1:0] fixo_concessao;
  logic                  rr_habilita;
  logic                  rr_encontrado;
  logic [NUM_CANAIS-1:0] rr_concessao;
  logic [SEL_W-1:0]      rr_indice;
  logic                  concede;
  logic [SEL_W-1:0]      canal_conc;
  logic [LARGURA-1:0]    dado_conc;

  // The output register can take new data when empty or being drained this cycle
  assign carregar   = !valido_q || resultado_pronto;
  assign transferir = valido_q && resultado_pronto;

  // controle may exceed the channel count when NUM_CANAIS is not a power of two
  assign controle_ok = (int'(controle) < NUM_CANAIS);

  // Fixed-select grant: only the addressed channel, only if it is requesting
  always_comb begin
    fixo_concede   = 1'b0;
    fixo_concessao = '0;
    if (!reset && carregar && (modo == MODO_FIXO) && controle_ok && validos[controle]) begin
      fixo_concede             = 1'b1;
      fixo_concessao[controle] = 1'b1;
    end
  end

  assign rr_habilita = !reset && carregar && (modo == MODO_RR);

  arbitro_rr #(
    .NUM_CANAIS (NUM_CANAIS)
  ) u_arbitro_rr (
    .pedidos_i    (validos),
    .ponteiro_i   (ponteiro_q),
    .habilita_i   (rr_habilita),
    .concessao_o  (rr_concessao),
    .indice_o     (rr_indice),
    .encontrado_o (rr_encontrado)
  );

  assign prontos    = (modo == MODO_RR) ? rr_concessao : fixo_concessao;
  assign concede    = (modo == MODO_RR) ? (rr_habilita && rr_encontrado) : fixo_concede;
  assign canal_conc = (modo == MODO_RR) ? rr_indice : controle;

  // Data of the granted channel
  always_comb begin
    dado_conc = '0;
    for (int i = 0; i < NUM_CANAIS; i++) begin
      if (int'(canal_conc) == i) begin
        dado_conc = entradas[i*LARGURA +: LARGURA];
      end
    end
  end

  // Next state: load on grant, drain on transfer, otherwise hold
  always_comb begin
    resultado_d = resultado_q;
    valido_d    = valido_q;
    canal_d     = canal_q;
    ponteiro_d  = ponteiro_q;
    if (concede) begin
      resultado_d = dado_conc;
      canal_d     = canal_conc;
      valido_d    = 1'b1;
      if (modo == MODO_RR) begin
        ponteiro_d = (int'(canal_conc) == NUM_CANAIS - 1) ? '0 : canal_conc + 1'b1;
      end
    end else if (transferir) begin
      valido_d = 1'b0;
    end
  end

  // Output register, channel tag and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      resultado_q <= '0;
      valido_q    <= 1'b0;
      canal_q     <= '0;
      ponteiro_q  <= '0;
    end else begin
      resultado_q <= resultado_d;
      valido_q    <= valido_d;
      canal_q     <= canal_d;
      ponteiro_q  <= ponteiro_d;
    end
  end

  assign resultado        = resultado_q;
  assign resultado_valido = valido_q;
  assign canal_atual      = canal_q;

`ifdef MUX_ARBITRADO_CONTADOR_EN
  logic [CONTADOR_W-1:0] contador_q, contador_d;

  // Count completed output transfers, wrapping naturally at full scale
  always_comb begin
    contador_d = contador_q;
    if (transferir) begin
      contador_d = contador_q + 1'b1;
    end
  end

  // Transfer counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      contador_q <= '0;
    end else begin
      contador_q <= contador_d;
    end
  end

  assign transferencias = contador_q;
`endif

endmodule

// File: tb/tb_mux_arbitrado.sv
// tb/tb_mux_arbitrado.sv - self-checking bench for mux_arbitrado
module tb_mux_arbitrado;

  localparam int NC = 4;
  localparam int W  = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [NC*W-1:0] entradas;
  logic [NC-1:0]   validos;
  logic [NC-1:0]   prontos;
  logic            modo;
  logic [1:0]      controle;
  logic [W-1:0]    resultado;
  logic            resultado_valido;
  logic            resultado_pronto;
  logic [1:0]      canal_atual;
`ifdef MUX_ARBITRADO_CONTADOR_EN
  logic [15:0]     transferencias;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] m_res = '0;
  bit           m_val = 1'b0;
  int           m_canal = 0;
  int           m_ptr = 0;
  int           m_cnt = 0;

  mux_arbitrado #(
    .LARGURA    (W),
    .NUM_CANAIS (NC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .entradas         (entradas),
    .validos          (validos),
    .prontos          (prontos),
    .modo             (modo),
    .controle         (controle),
    .resultado        (resultado),
    .resultado_valido (resultado_valido),
    .resultado_pronto (resultado_pronto),
    .canal_atual      (canal_atual)
`ifdef MUX_ARBITRADO_CONTADOR_EN
    ,
    .transferencias   (transferencias)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  // Which channel the rules grant this cycle, -1 for none
  function automatic int modelo_conc();
    int c;
    if (reset) return -1;
    if (m_val && !resultado_pronto) return -1;
    if (modo == 1'b0) begin
      if (int'(controle) < NC && validos[controle]) return int'(controle);
      return -1;
    end
    for (int k = 0; k < NC; k++) begin
      c = (m_ptr + k) % NC;
      if (validos[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] onehot(input int g);
    logic [NC-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Advance one clock: update model at the edge, return at the following negedge
  task automatic avanca();
    int g;
    bit tr;
    g  = modelo_conc();
    tr = m_val && resultado_pronto;
    @(posedge clock);
    if (reset) begin
      m_res = '0; m_val = 1'b0; m_canal = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (tr) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_val = 1'b0;
      end
      if (g >= 0) begin
        m_res   = entradas[g*W +: W];
        m_canal = g;
        m_val   = 1'b1;
        if (modo) m_ptr = (g + 1) % NC;
      end
    end
    @(negedge clock);
  endtask

  task automatic aplica_reset();
    reset = 1'b1;
    avanca();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; validos = 4'hF; resultado_pronto = 1'b1; modo = 1'b1;
    #1;
    checks++; if (prontos !== 4'b0000) begin errors++; $display("FAIL reset_prontos: got %b expected 0000", prontos); end
    avanca();
    checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL reset_resultado: got %h expected 00", resultado); end
    checks++; if (resultado_valido !== 1'b0) begin errors++; $display("FAIL reset_valido: got %b expected 0", resultado_valido); end
    checks++; if (canal_atual !== 2'd0) begin errors++; $display("FAIL reset_canal: got %0d expected 0", canal_atual); end
    reset = 1'b0;
  endtask

  task automatic test_fixed();
    modo = 1'b0; controle = 2'd2; validos = 4'b0110; resultado_pronto = 1'b1;
    entradas = 32'h11_A5_22_33;
    #1;
    checks++; if (prontos !== 4'b0100) begin errors++; $display("FAIL fixo_prontos: got %b expected 0100", prontos); end
    avanca();
    checks++; if (resultado !== 8'hA5) begin errors++; $display("FAIL fixo_resultado: got %h expected a5", resultado); end
    checks++; if (canal_atual !== 2'd2) begin errors++; $display("FAIL fixo_canal: got %0d expected 2", canal_atual); end
    checks++; if (resultado_valido !== 1'b1) begin errors++; $display("FAIL fixo_valido: got %b expected 1", resultado_valido); end
  endtask

  task automatic test_round_robin();
    int esperado[5] = '{0, 1, 2, 3, 0};
    modo = 1'b1; validos = 4'hF; resultado_pronto = 1'b1;
    entradas = 32'h13_12_11_10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (prontos !== onehot(esperado[i])) begin errors++; $display("FAIL rr_prontos[%0d]: got %b expected %b", i, prontos, onehot(esperado[i])); end
      avanca();
      checks++; if (canal_atual !== 2'(esperado[i])) begin errors++; $display("FAIL rr_canal[%0d]: got %0d expected %0d", i, canal_atual, esperado[i]); end
      checks++; if (resultado !== 8'(8'h10 + esperado[i])) begin errors++; $display("FAIL rr_resultado[%0d]: got %h expected %h", i, resultado, 8'h10 + esperado[i]); end
      checks++; if (resultado_valido !== 1'b1) begin errors++; $display("FAIL rr_valido[%0d]: got %b expected 1", i, resultado_valido); end
    end
  endtask

  task automatic test_back_pressure();
    modo = 1'b0; controle = 2'd1; validos = 4'b0010; resultado_pronto = 1'b1;
    entradas = 32'h00_00_3C_00;
    #1;
    checks++; if (prontos !== 4'b0010) begin errors++; $display("FAIL bp_carga_prontos: got %b expected 0010", prontos); end
    avanca();
    checks++; if (resultado !== 8'h3C) begin errors++; $display("FAIL bp_carga: got %h expected 3c", resultado); end
    resultado_pronto = 1'b0;
    entradas = 32'h00_00_77_00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (prontos !== 4'b0000) begin errors++; $display("FAIL bp_prontos[%0d]: got %b expected 0000", i, prontos); end
      avanca();
      checks++; if (resultado !== 8'h3C || resultado_valido !== 1'b1 || canal_atual !== 2'd1) begin
        errors++; $display("FAIL bp_hold[%0d]: got %h/%b/%0d expected 3c/1/1", i, resultado, resultado_valido, canal_atual);
      end
    end
    resultado_pronto = 1'b1;
    #1;
    checks++; if (prontos !== 4'b0010) begin errors++; $display("FAIL bp_retoma_prontos: got %b expected 0010", prontos); end
    avanca();
    checks++; if (resultado !== 8'h77) begin errors++; $display("FAIL bp_retoma: got %h expected 77", resultado); end
  endtask

  task automatic test_pointer_wrap();
    aplica_reset();
    modo = 1'b1; resultado_pronto = 1'b1; validos = 4'b0100;
    entradas = 32'h44_33_22_11;
    #1;
    checks++; if (prontos !== 4'b0100) begin errors++; $display("FAIL ptr_prep: got %b expected 0100", prontos); end
    avanca();
    validos = 4'b0010;
    #1;
    checks++; if (prontos !== 4'b0010) begin errors++; $display("FAIL ptr_wrap_prontos: got %b expected 0010", prontos); end
    avanca();
    checks++; if (canal_atual !== 2'd1 || resultado !== 8'h22) begin errors++; $display("FAIL ptr_wrap_saida: got %0d/%h expected 1/22", canal_atual, resultado); end
    validos = 4'hF;
    #1;
    checks++; if (prontos !== 4'b0100) begin errors++; $display("FAIL ptr_novo_valor: got %b expected 0100", prontos); end
    avanca();
  endtask

  task automatic test_reset_mid();
    modo = 1'b1; validos = 4'b0010; resultado_pronto = 1'b1;
    entradas = 32'h44_33_5A_11;
    avanca();
    resultado_pronto = 1'b0; validos = 4'hF;
    #1;
    checks++; if (prontos !== 4'b0000) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0000", prontos); end
    avanca();
    reset = 1'b1;
    #1;
    checks++; if (prontos !== 4'b0000) begin errors++; $display("FAIL rst_mid_prontos: got %b expected 0000", prontos); end
    avanca();
    reset = 1'b0;
    checks++; if (resultado_valido !== 1'b0 || resultado !== 8'h00 || canal_atual !== 2'd0) begin
      errors++; $display("FAIL rst_mid_saida: got %b/%h/%0d expected 0/00/0", resultado_valido, resultado, canal_atual);
    end
    resultado_pronto = 1'b1;
    #1;
    checks++; if (prontos !== 4'b0001) begin errors++; $display("FAIL rst_mid_ponteiro: got %b expected 0001", prontos); end
    avanca();
  endtask

  task automatic test_no_valid();
    validos = 4'b0000; resultado_pronto = 1'b1; modo = 1'b1;
    #1;
    checks++; if (prontos !== 4'b0000) begin errors++; $display("FAIL sem_validos_prontos: got %b expected 0000", prontos); end
    avanca();
    checks++; if (resultado_valido !== 1'b0) begin errors++; $display("FAIL sem_validos_drena: got %b expected 0", resultado_valido); end
  endtask

  task automatic test_random();
    logic [NC-1:0] exp_p;
    for (int i = 0; i < 400; i++) begin
      entradas         = $urandom;
      validos          = 4'($urandom_range(0, 15));
      modo             = 1'($urandom_range(0, 1));
      controle         = 2'($urandom_range(0, 3));
      resultado_pronto = ($urandom_range(0, 3) != 0);
      reset            = ($urandom_range(0, 49) == 0);
      #1;
      exp_p = onehot(modelo_conc());
      checks++; if (prontos !== exp_p) begin errors++; $display("FAIL rand_prontos[%0d]: got %b expected %b", i, prontos, exp_p); end
      avanca();
      checks++; if (resultado_valido !== m_val || canal_atual !== 2'(m_canal) || resultado !== m_res) begin
        errors++; $display("FAIL rand_saida[%0d]: got %b/%0d/%h expected %b/%0d/%h", i, resultado_valido, canal_atual, resultado, m_val, m_canal, m_res);
      end
`ifdef MUX_ARBITRADO_CONTADOR_EN
      checks++; if (transferencias !== 16'(m_cnt)) begin errors++; $display("FAIL rand_contador[%0d]: got %0d expected %0d", i, transferencias, m_cnt); end
`endif
    end
    reset = 1'b0;
  endtask

`ifdef MUX_ARBITRADO_CONTADOR_EN
  task automatic test_counter();
    aplica_reset();
    modo = 1'b0; controle = 2'd0; validos = 4'b0001; resultado_pronto = 1'b1;
    entradas = $urandom;
    repeat (5) avanca();
    validos = 4'b0000;
    avanca();
    checks++; if (transferencias !== 16'd5) begin errors++; $display("FAIL cont_cinco: got %0d expected 5", transferencias); end
    aplica_reset();
    checks++; if (transferencias !== 16'd0) begin errors++; $display("FAIL cont_reset: got %0d expected 0", transferencias); end
    validos = 4'b0001;
    repeat (65536) avanca();
    checks++; if (transferencias !== 16'hFFFF) begin errors++; $display("FAIL cont_cheio: got %h expected ffff", transferencias); end
    avanca();
    checks++; if (transferencias !== 16'h0000) begin errors++; $display("FAIL cont_volta: got %h expected 0000", transferencias); end
  endtask
`endif

  initial begin
    reset = 1'b1; entradas = '0; validos = '0; modo = 1'b0; controle = '0; resultado_pronto = 1'b0;
    @(negedge clock);
    test_reset();
    test_fixed();
    test_round_robin();
    test_back_pressure();
    test_pointer_wrap();
    test_reset_mid();
    test_no_valid();
    test_random();
`ifdef MUX_ARBITRADO_CONTADOR_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
